// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time program loader that sits in front of
// single_cycle_processor.
//   loader_state_t : loader FSM encoding (3-bit)
//   WORD_BYTES     : bytes per instruction word
//   INSTR_WIDTH    : instruction word width
//   BYTE_CNT_W     : width of the byte-within-word counter
package mips_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int INSTR_WIDTH = 32;
    localparam int BYTE_CNT_W  = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Bus bundle between the host byte stream, the loader and the processor.
//   START/LEN                 : load request (LEN in words, sampled on START)
//   RX_DATA/RX_VALID/RX_READY : program byte stream handshake
//   IM_WE/IM_ADDR/IM_WDATA    : instruction-memory write port
//   PCRRST/RFRST/DMRST        : processor resets (active-high)
//   BUSY/DONE                 : loader status
// Modports: slave = the loader, master = host / processor side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    import mips_pkg::*;

    logic                   START;
    logic [ADDR_WIDTH:0]    LEN;
    logic [7:0]             RX_DATA;
    logic                   RX_VALID;
    logic                   RX_READY;
    logic                   IM_WE;
    logic [ADDR_WIDTH-1:0]  IM_ADDR;
    logic [INSTR_WIDTH-1:0] IM_WDATA;
    logic                   PCRRST;
    logic                   RFRST;
    logic                   DMRST;
    logic                   BUSY;
    logic                   DONE;

    modport slave (
        input  START, LEN, RX_DATA, RX_VALID,
        output RX_READY, IM_WE, IM_ADDR, IM_WDATA,
        output PCRRST, RFRST, DMRST, BUSY, DONE
    );

    modport master (
        output START, LEN, RX_DATA, RX_VALID,
        input  RX_READY, IM_WE, IM_ADDR, IM_WDATA,
        input  PCRRST, RFRST, DMRST, BUSY, DONE
    );

endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words.
//   CLK, RSTN   : clock, asynchronous active-low reset
//   i_clear     : restart the byte count (new load)
//   i_accept    : a byte is transferred this cycle
//   i_byte      : the byte
//   o_word_done : this accept completes a word
//   o_word      : shift register contents (first byte ends up in [31:24])
module byte_packer
    import mips_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   i_clear,
    input  logic                   i_accept,
    input  logic [7:0]             i_byte,
    output logic                   o_word_done,
    output logic [INSTR_WIDTH-1:0] o_word
);

    logic [BYTE_CNT_W-1:0]  r_cnt;
    logic [INSTR_WIDTH-1:0] r_word;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            // The counter wraps naturally from the last byte back to zero.
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (i_accept) begin
                r_word <= {r_word[INSTR_WIDTH-9:0], i_byte};
            end
        end
    end

    assign o_word_done = i_accept && (r_cnt == BYTE_CNT_W'(WORD_BYTES - 1));
    assign o_word      = r_word;

endmodule

// File: rtl/program_loader.sv
// Boot loader for single_cycle_processor: receives a program as bytes,
// writes 32-bit big-endian words into instruction memory, then releases the
// processor resets in the order DMRST, RFRST, PCRRST (PC starts last).
//   CLK, RSTN : clock, asynchronous active-low reset
//   bus       : program_loader_if.slave (stream in, IM write, resets, status)
module program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int RELEASE_GAP = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    program_loader_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int REL_W = $clog2(2 * RELEASE_GAP + 1);

    loader_state_t          r_state;
    loader_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0]  r_word_idx;
    logic [ADDR_WIDTH-1:0]  r_last_idx;
    logic [REL_W-1:0]       r_rel_cnt;

    logic                   w_start_ok;
    logic                   w_accept;
    logic                   w_word_done;
    logic [INSTR_WIDTH-1:0] w_word;
    logic [ADDR_WIDTH-1:0]  w_last_idx;

    logic w_rx_ready, w_im_we, w_busy, w_done;
    logic w_pcrrst, w_rfrst, w_dmrst;

    assign w_start_ok = bus.START && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_accept   = bus.RX_VALID && (r_state == S_LOAD);

    // Storing LEN-1 handles the clamp for free: LEN == DEPTH truncates to
    // all-ones, anything above is forced there too.
    assign w_last_idx = (bus.LEN >= (ADDR_WIDTH + 1)'(DEPTH)) ? '1
                                                              : ADDR_WIDTH'(bus.LEN - 1'b1);

    byte_packer u_packer (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .i_clear     (w_start_ok),
        .i_accept    (w_accept),
        .i_byte      (bus.RX_DATA),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_rel_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_word_idx <= '0;
                r_last_idx <= w_last_idx;
            end else if ((r_state == S_WRITE) && (w_next_state == S_LOAD)) begin
                r_word_idx <= r_word_idx + 1'b1;
            end
            r_rel_cnt <= (r_state == S_RELEASE) ? r_rel_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rx_ready   = 1'b0;
        w_im_we      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_pcrrst     = 1'b1;
        w_rfrst      = 1'b1;
        w_dmrst      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_next_state = (bus.LEN == '0) ? S_RELEASE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_rx_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_done) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_im_we      = 1'b1;
                w_busy       = 1'b1;
                w_next_state = (r_word_idx == r_last_idx) ? S_RELEASE : S_LOAD;
            end
            S_RELEASE: begin
                // DMRST drops on entry, RFRST after one gap, PCRRST (and RUN)
                // after a second gap.
                w_busy  = 1'b1;
                w_dmrst = 1'b0;
                w_rfrst = (r_rel_cnt < REL_W'(RELEASE_GAP));
                if (r_rel_cnt == REL_W'(2 * RELEASE_GAP - 1)) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_done   = 1'b1;
                w_pcrrst = 1'b0;
                w_rfrst  = 1'b0;
                w_dmrst  = 1'b0;
                if (bus.START) begin
                    w_next_state = (bus.LEN == '0) ? S_RELEASE : S_LOAD;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign bus.RX_READY = w_rx_ready;
    assign bus.IM_WE    = w_im_we;
    assign bus.IM_ADDR  = r_word_idx;
    assign bus.IM_WDATA = w_word;
    assign bus.PCRRST   = w_pcrrst;
    assign bus.RFRST    = w_rfrst;
    assign bus.DMRST    = w_dmrst;
    assign bus.BUSY     = w_busy;
    assign bus.DONE     = w_done;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a phase-level model predicts the
// outputs every cycle, a program scoreboard checks every written word, and
// directed literal checks pin the model on the key scenarios.
module tb_program_loader;

    localparam int AW  = 8;
    localparam int GAP = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(.ADDR_WIDTH(AW), .RELEASE_GAP(GAP)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // program scoreboard
    int          exp_addr[$];
    logic [31:0] exp_data[$];

    // phase-level model: 0 idle, 1 loading, 2 releasing, 3 running
    int          m_phase = 0;
    int          m_len = 0, m_writes = 0, m_nb = 0, m_t = 0;
    bit          m_wep = 1'b0;
    logic [31:0] m_acc = '0;
    logic        e_pc, e_rf, e_dm, e_rdy, e_we, e_busy, e_done;

    // observations
    int          t_dm_fall = 0, t_rf_fall = 0, t_pc_fall = 0, t_done_rise = 0;
    int          t_we_last = 0, t_acc4 = 0, t_start = 0, n_we = 0;
    int          last_addr = 0;
    logic [31:0] last_data = '0;
    logic        p_dm = 1'b1, p_rf = 1'b1, p_pc = 1'b1, p_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int j);
        return w[31-8*j -: 8];
    endfunction

    function automatic logic [31:0] pat(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((i * 4 + j) * 7 + 3);
        return w;
    endfunction

    // ---------------- compare process ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (p_dm && !bus.DMRST)   t_dm_fall   = cyc;
            if (p_rf && !bus.RFRST)   t_rf_fall   = cyc;
            if (p_pc && !bus.PCRRST)  t_pc_fall   = cyc;
            if (!p_done && bus.DONE)  t_done_rise = cyc;
            p_dm = bus.DMRST; p_rf = bus.RFRST; p_pc = bus.PCRRST; p_done = bus.DONE;

            if (!rstn) begin
                chk("rst_pcrrst", bus.PCRRST, 1);
                chk("rst_rfrst", bus.RFRST, 1);
                chk("rst_dmrst", bus.DMRST, 1);
                chk("rst_rx_ready", bus.RX_READY, 0);
                chk("rst_im_we", bus.IM_WE, 0);
                chk("rst_busy", bus.BUSY, 0);
                chk("rst_done", bus.DONE, 0);
                chk("rst_im_addr", bus.IM_ADDR, 0);
                chk("rst_im_wdata", bus.IM_WDATA, 0);
                m_phase = 0; m_wep = 1'b0; m_nb = 0;
            end else begin
                case (m_phase)
                    1: begin
                        e_pc = 1; e_rf = 1; e_dm = 1; e_rdy = !m_wep; e_we = m_wep;
                        e_busy = 1; e_done = 0;
                    end
                    2: begin
                        e_pc = 1; e_rf = (m_t < GAP); e_dm = 0; e_rdy = 0; e_we = 0;
                        e_busy = 1; e_done = 0;
                    end
                    3: begin
                        e_pc = 0; e_rf = 0; e_dm = 0; e_rdy = 0; e_we = 0;
                        e_busy = 0; e_done = 1;
                    end
                    default: begin
                        e_pc = 1; e_rf = 1; e_dm = 1; e_rdy = 0; e_we = 0;
                        e_busy = 0; e_done = 0;
                    end
                endcase
                chk("pcrrst", bus.PCRRST, e_pc);
                chk("rfrst", bus.RFRST, e_rf);
                chk("dmrst", bus.DMRST, e_dm);
                chk("rx_ready", bus.RX_READY, e_rdy);
                chk("im_we", bus.IM_WE, e_we);
                chk("busy", bus.BUSY, e_busy);
                chk("done", bus.DONE, e_done);

                if (bus.IM_WE) begin
                    n_we++; t_we_last = cyc;
                    last_addr = bus.IM_ADDR; last_data = bus.IM_WDATA;
                    $display("write addr=%0d data=%08h", bus.IM_ADDR, bus.IM_WDATA);
                end

                case (m_phase)
                    0, 3: begin
                        if (bus.START) begin
                            t_start = cyc;
                            m_len = (int'(bus.LEN) > (1 << AW)) ? (1 << AW) : int'(bus.LEN);
                            if (m_len == 0) begin
                                m_phase = 2; m_t = 0;
                            end else begin
                                m_phase = 1; m_writes = 0; m_nb = 0; m_wep = 1'b0;
                            end
                        end
                    end
                    1: begin
                        if (m_wep) begin
                            chk("we_addr_vs_index", bus.IM_ADDR, m_writes);
                            chk("we_data_vs_bytes", bus.IM_WDATA, m_acc);
                            chk("scoreboard_nonempty", exp_data.size() > 0, 1);
                            if (exp_data.size() > 0) begin
                                chk("we_addr_vs_program", bus.IM_ADDR, exp_addr.pop_front());
                                chk("we_data_vs_program", bus.IM_WDATA, exp_data.pop_front());
                            end
                            m_wep = 1'b0;
                            m_writes++;
                            if (m_writes == m_len) begin
                                m_phase = 2; m_t = 0;
                            end
                        end else if (bus.RX_VALID) begin
                            m_acc = {m_acc[23:0], bus.RX_DATA};
                            m_nb++;
                            if (m_nb == 4) begin
                                m_nb = 0; m_wep = 1'b1; t_acc4 = cyc;
                            end
                        end
                    end
                    2: begin
                        if (m_t == 2 * GAP - 1) m_phase = 3;
                        else m_t++;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic do_start(input int len);
        bus.LEN   = (AW + 1)'(len);
        bus.START = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        @(negedge clk);
        while (!bus.RX_READY && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("rx_ready_wait", bus.RX_READY, 1);
        @(posedge clk); #1;
        bus.RX_VALID = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int j = 0; j < 4; j++) send_byte(byte_of(w, j), gap);
    endtask

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.DONE && n < budget) begin
            n++;
            @(negedge clk);
        end
        chk("done_reached", bus.DONE, 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int          n0;
        int          gt[12];
        logic [31:0] w3[3];
        gt = '{0, 2, 1, 0, 3, 0, 0, 1, 0, 0, 4, 2};
        w3 = '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'hDEADBEEF};

        bus.START = 1'b0; bus.LEN = '0; bus.RX_VALID = 1'b0; bus.RX_DATA = '0;
        #1 rstn = 1'b0;
        #1;
        chk("init_pcrrst", bus.PCRRST, 1);
        chk("init_rfrst", bus.RFRST, 1);
        chk("init_dmrst", bus.DMRST, 1);
        chk("init_done", bus.DONE, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // single word, release timing
        n0 = n_we;
        push_exp(0, 32'h20080005);
        do_start(1);
        send_byte(8'h20, 0); send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        wait_done(40);
        chk("single_n_we", n_we - n0, 1);
        chk("single_addr", last_addr, 0);
        chk("single_data", last_data, 32'h20080005);
        chk("single_we_latency", t_we_last - t_acc4, 1);
        chk("rel_dm_after_we", t_dm_fall - t_we_last, 1);
        chk("rel_rf_gap", t_rf_fall - t_dm_fall, 4);
        chk("rel_pc_gap", t_pc_fall - t_rf_fall, 4);
        chk("rel_done_with_pc", t_done_rise, t_pc_fall);

        // asynchronous reset from RUN, checked without a clock edge
        #1 rstn = 1'b0;
        #1;
        chk("async_pcrrst", bus.PCRRST, 1);
        chk("async_rfrst", bus.RFRST, 1);
        chk("async_dmrst", bus.DMRST, 1);
        chk("async_done", bus.DONE, 0);
        chk("async_busy", bus.BUSY, 0);
        chk("async_im_addr", bus.IM_ADDR, 0);
        chk("async_im_wdata", bus.IM_WDATA, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // three words with gaps
        n0 = n_we;
        for (int i = 0; i < 3; i++) push_exp(i, w3[i]);
        do_start(3);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) send_byte(byte_of(w3[i], j), gt[i*4+j]);
        wait_done(40);
        chk("gaps_n_we", n_we - n0, 3);
        chk("gaps_last_addr", last_addr, 2);
        chk("gaps_last_data", last_data, 32'hDEADBEEF);

        // LEN=0 from IDLE
        reset_pulse();
        n0 = n_we;
        do_start(0);
        wait_done(40);
        chk("len0_n_we", n_we - n0, 0);
        chk("len0_dm_after_start", t_dm_fall - t_start, 1);

        // START while running
        n0 = n_we;
        push_exp(0, 32'h12345678);
        do_start(1);
        chk("rerun_pcrrst", bus.PCRRST, 1);
        chk("rerun_rfrst", bus.RFRST, 1);
        chk("rerun_dmrst", bus.DMRST, 1);
        chk("rerun_busy", bus.BUSY, 1);
        send_word(32'h12345678, 0);
        wait_done(40);
        chk("rerun_n_we", n_we - n0, 1);
        chk("rerun_data", last_data, 32'h12345678);

        // reset after two bytes abandons the load
        reset_pulse();
        do_start(2);
        send_byte(8'h77, 0); send_byte(8'h66, 0);
        reset_pulse();
        n0 = n_we;
        push_exp(0, 32'hCAFEF00D);
        do_start(1);
        send_word(32'hCAFEF00D, 1);
        wait_done(40);
        chk("abort_n_we", n_we - n0, 1);
        chk("abort_addr", last_addr, 0);
        chk("abort_data", last_data, 32'hCAFEF00D);

        // LEN above depth is clamped
        reset_pulse();
        n0 = n_we;
        for (int i = 0; i < 256; i++) push_exp(i, pat(i));
        do_start(300);
        for (int i = 0; i < 256; i++) send_word(pat(i), 0);
        wait_done(40);
        chk("clamp_n_we", n_we - n0, 256);
        chk("clamp_last_addr", last_addr, 255);
        chk("clamp_scoreboard_empty", exp_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of single_cycle_processor.
- Receives a program as a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words.
- Writes each word into the processor's instruction memory.
- Holds the processor's PCRRST/RFRST/DMRST asserted during the load, then releases them in a fixed staged order so the PC starts last.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width (depth = 2**ADDR_WIDTH words).
- RELEASE_GAP, 4, cycles between successive reset deassertions (must be ≥1).

Ports:
- CLK  in  1  system clock, rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  single-cycle pulse; begins a load.
- LEN  in  ADDR_WIDTH+1  number of words to load; sampled on START.
- RX_DATA  in  8  program byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- IM_WE  out  1  instruction-memory write enable.
- IM_ADDR  out  ADDR_WIDTH  word address.
- IM_WDATA  out  32  word to write.
- PCRRST  out  1  processor PC reset, active-high.
- RFRST  out  1  register-file reset, active-high.
- DMRST  out  1  data-memory reset, active-high.
- BUSY  out  1  high in LOAD, WRITE and RELEASE.
- DONE  out  1  high in RUN.

Behaviour:
- Reset: RSTN low asynchronously forces state IDLE and clears all counters.
  - Outputs during reset: PCRRST=RFRST=DMRST=1; RX_READY=IM_WE=BUSY=DONE=0; IM_ADDR=0; IM_WDATA=0.
  - Reset mid-load abandons the load. Words already written are not erased.
- All outputs are registered (driven from state and registers, not from inputs).
- Byte handshake: a byte transfers on a rising edge where RX_VALID && RX_READY. RX_READY is high only in LOAD.
- IDLE:
  - Processor resets held high.
  - START with LEN==0 → RELEASE.
  - START with LEN>0 → LOAD, with word index 0 and byte count 0.
  - LEN > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH when sampled.
- LOAD:
  - Accepted bytes shift in MSB-first: 1st byte → IM_WDATA[31:24], 4th byte → [7:0].
  - The 2-bit byte count wraps 3→0. On the 4th accept, next state is WRITE.
  - RX_VALID low stalls indefinitely with no timeout.
- WRITE:
  - Exactly one cycle long: IM_WE=1, IM_ADDR=current word index, IM_WDATA=assembled word, RX_READY=0.
  - Latency: 4th byte accepted at edge k → IM_WE high for the cycle following edge k.
  - If word index == LEN-1 → RELEASE. Otherwise increment the word index and return to LOAD.
  - The word index never wraps because LEN is clamped.
- RELEASE (staged reset deassertion, counter-driven):
  - DMRST goes low on entry.
  - RFRST goes low RELEASE_GAP cycles later.
  - PCRRST goes low a further RELEASE_GAP cycles later; the state becomes RUN in the same cycle.
- RUN:
  - All processor resets low; DONE=1.
  - START → reload: all three resets re-assert on the next edge, then the same LEN handling as IDLE (LOAD, or RELEASE if LEN==0).
- START is ignored in LOAD, WRITE and RELEASE. LEN is only sampled on an accepted START.
- Simultaneous START and RX_VALID in IDLE or RUN: the byte is not accepted, because RX_READY is 0 that cycle.

Decomposition:
- Shared package mips_pkg holds:
  - State encoding: IDLE=0, LOAD=1, WRITE=2, RELEASE=3, RUN=4 (3-bit).
  - Constants WORD_BYTES=4 and INSTR_WIDTH=32.
- One natural sub-module, byte_packer: shift register plus 2-bit byte counter, with ports byte-accept, byte-in, word-complete and 32-bit word out.
- The FSM, word-index counter and release counter stay in program_loader.

Test Plan:
- Reset values: assert RSTN low mid-cycle → all outputs take reset values immediately, with no clock edge needed; PCRRST=RFRST=DMRST=1.
- Single word: START with LEN=1, then bytes 0x20,0x08,0x00,0x05 with RX_VALID held high → one IM_WE pulse with IM_ADDR=0 and IM_WDATA=0x20080005, one cycle after the 4th accept.
- Release timing for that same load:
  - DMRST falls on RELEASE entry.
  - RFRST falls 4 cycles later.
  - PCRRST falls 4 cycles after that, together with DONE rising.
- Backpressure and gaps: LEN=3 with random RX_VALID gaps → exactly 3 writes at addresses 0,1,2 with correct words; no byte lost or duplicated; RX_READY=0 during each WRITE cycle.
- Edge cases:
  - LEN=0 → no IM_WE; release sequence starts directly.
  - LEN=300 with ADDR_WIDTH=8 → exactly 256 writes, last at IM_ADDR=255.
- Mid-operation events:
  - RSTN pulsed low after 2 bytes → IDLE, and the next START restarts at IM_ADDR=0 with the byte count cleared.
  - START in RUN → the three resets re-assert on the next edge and a new load runs.
